// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types and constants for the RV32I multicycle core
package riscv_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0013;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, FAULT} fetch_state_t;
    typedef enum logic [1:0] {NONE, MISALIGNED, BUS_TIMEOUT} fetch_fault_t;
endpackage

// File: rtl/fetch_watchdog.sv
// fetch_watchdog: counts enabled cycles and flags expiry on the LIMIT-th one
module fetch_watchdog #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    logic [7:0] count;
    assign expired = enable && (count == 8'(LIMIT - 1));
    always_ff @(posedge clk)
        if (rst || clear) count <= '0;
        else if (enable && !expired) count <= count + 8'd1;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: multicycle RV32I fetch over a req/gnt/rvalid instruction bus
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter logic [31:0] NOP_INSN = riscv_pkg::NOP_INSN
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    input  logic        fetch_start,
    input  logic        ir_consume,
    input  logic        fault_clear,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir_out,
    output logic [31:0] pc_ir,
    output logic        ir_valid,
    output logic [31:0] pc_next,
    output logic        pc_write,
    output logic        busy,
    output logic        fault,
    output logic [1:0]  fault_cause
);
    fetch_state_t state;
    logic wd_expired;
    fetch_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_wd (
        .clk(clk),
        .rst(rst),
        .clear(state == REQ && imem_gnt),
        .enable(state == WAIT),
        .expired(wd_expired)
    );
    // imem_addr doubles as the latched fetch PC; it only changes on aligned accepts
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            imem_req    <= 1'b0;
            imem_addr   <= '0;
            ir_out      <= NOP_INSN;
            pc_ir       <= '0;
            pc_next     <= '0;
            ir_valid    <= 1'b0;
            pc_write    <= 1'b0;
            busy        <= 1'b0;
            fault       <= 1'b0;
            fault_cause <= NONE;
        end else begin
            pc_write <= 1'b0;
            if (ir_consume) ir_valid <= 1'b0;
            case (state)
                IDLE: if (fetch_start && (!ir_valid || ir_consume)) begin
                    busy <= 1'b1;
                    if (pc_in[1:0] != 2'b00) begin
                        state       <= FAULT;
                        fault       <= 1'b1;
                        fault_cause <= MISALIGNED;
                    end else begin
                        state     <= REQ;
                        imem_req  <= 1'b1;
                        imem_addr <= pc_in;
                    end
                end
                REQ: if (imem_gnt) begin
                    state    <= WAIT;
                    imem_req <= 1'b0;
                end
                WAIT: if (imem_rvalid) begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    ir_out   <= imem_rdata;
                    pc_ir    <= imem_addr;
                    pc_next  <= imem_addr + 32'd4;
                    ir_valid <= 1'b1;
                    pc_write <= 1'b1;
                end else if (wd_expired) begin
                    state       <= FAULT;
                    fault       <= 1'b1;
                    fault_cause <= BUS_TIMEOUT;
                end
                FAULT: if (fault_clear) begin
                    state       <= IDLE;
                    busy        <= 1'b0;
                    fault       <= 1'b0;
                    fault_cause <= NONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed and random fetches checked against a transaction-level model
module tb_instr_fetch_unit;
    localparam int T = 4;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_in = '0;
    logic        fetch_start = 1'b0, ir_consume = 1'b0, fault_clear = 1'b0;
    logic        imem_gnt = 1'b0, imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_req, ir_valid, pc_write, busy, fault;
    logic [31:0] imem_addr, ir_out, pc_ir, pc_next;
    logic [1:0]  fault_cause;
    int passed = 0, total = 0;

    instr_fetch_unit #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .fetch_start(fetch_start),
        .ir_consume(ir_consume), .fault_clear(fault_clear),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .ir_out(ir_out), .pc_ir(pc_ir), .ir_valid(ir_valid), .pc_next(pc_next),
        .pc_write(pc_write), .busy(busy), .fault(fault), .fault_cause(fault_cause)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    // Expected outputs; the fetch phase is inferred from them rather than kept as a state
    logic        e_req = 0, e_valid = 0, e_pcw = 0, e_busy = 0, e_fault = 0;
    logic [31:0] e_addr = 0, e_ir = 32'h13, e_pcir = 0, e_pcn = 0;
    logic [1:0]  e_cause = 0;
    int          waited = 0;
    bit          armed = 0;

    always @(posedge clk) begin
        bit waiting, load;
        if (rst) begin
            e_req = 0; e_addr = 0; e_ir = 32'h13; e_pcir = 0; e_pcn = 0;
            e_valid = 0; e_pcw = 0; e_busy = 0; e_fault = 0; e_cause = 0; waited = 0;
        end else begin
            waiting = e_busy && !e_req && !e_fault;
            load = waiting && imem_rvalid;
            e_pcw = 0;
            if (load) begin
                e_ir = imem_rdata; e_pcir = e_addr; e_pcn = e_addr + 32'd4;
                e_valid = 1; e_pcw = 1; e_busy = 0;
            end else if (waiting) begin
                waited++;
                if (waited == T) begin e_fault = 1; e_cause = 2; end
            end else if (e_fault) begin
                if (fault_clear) begin e_fault = 0; e_cause = 0; e_busy = 0; end
            end else if (e_req) begin
                if (imem_gnt) begin e_req = 0; waited = 0; end
            end else if (fetch_start && (!e_valid || ir_consume)) begin
                e_busy = 1;
                if (pc_in[1:0] != 2'b00) begin e_fault = 1; e_cause = 1; end
                else begin e_req = 1; e_addr = pc_in; end
            end
            if (ir_consume && !load) e_valid = 0;
        end
        armed = 1;
    end

    always @(negedge clk) if (armed) begin
        cmp("imem_req", 32'(imem_req), 32'(e_req));
        if (e_req) cmp("imem_addr", imem_addr, e_addr);
        cmp("ir_out", ir_out, e_ir);
        cmp("pc_ir", pc_ir, e_pcir);
        cmp("pc_next", pc_next, e_pcn);
        cmp("ir_valid", 32'(ir_valid), 32'(e_valid));
        cmp("pc_write", 32'(pc_write), 32'(e_pcw));
        cmp("busy", 32'(busy), 32'(e_busy));
        cmp("fault", 32'(fault), 32'(e_fault));
        cmp("fault_cause", 32'(fault_cause), 32'(e_cause));
    end

    // Returns on the negedge where the loaded instruction is visible
    task automatic do_fetch(input logic [31:0] pc, input int gd, input int rd,
                            input logic [31:0] data, input bit consume);
        fetch_start = 1; ir_consume = consume; pc_in = pc;
        @(negedge clk);
        fetch_start = 0; ir_consume = 0;
        repeat (gd) begin imem_rvalid = 1'($urandom); @(negedge clk); end
        imem_rvalid = 0; imem_gnt = 1;
        @(negedge clk);
        imem_gnt = 0;
        repeat (rd) @(negedge clk);
        imem_rvalid = 1; imem_rdata = data;
        @(negedge clk);
        imem_rvalid = 0;
    endtask

    initial begin
        logic [31:0] d;
        repeat (2) @(negedge clk);
        cmp("rst ir_out", ir_out, 32'h0000_0013);
        cmp("rst busy", 32'(busy), 0);
        cmp("rst ir_valid", 32'(ir_valid), 0);
        cmp("rst imem_addr", imem_addr, 0);
        rst = 0;
        @(negedge clk);
        do_fetch(32'h20, 0, 0, 32'h0050_0093, 0);
        cmp("best ir_out", ir_out, 32'h0050_0093);
        cmp("best pc_ir", pc_ir, 32'h20);
        cmp("best pc_next", pc_next, 32'h24);
        cmp("best pc_write", 32'(pc_write), 1);
        cmp("best ir_valid", 32'(ir_valid), 1);
        @(negedge clk);
        cmp("best pc_write width", 32'(pc_write), 0);
        fetch_start = 1; pc_in = 32'h30;
        @(negedge clk);
        fetch_start = 0;
        cmp("stall imem_req", 32'(imem_req), 0);
        cmp("stall busy", 32'(busy), 0);
        fetch_start = 1; ir_consume = 1;
        @(negedge clk);
        fetch_start = 0; ir_consume = 0;
        cmp("consume imem_req", 32'(imem_req), 1);
        cmp("consume imem_addr", imem_addr, 32'h30);
        imem_gnt = 1;
        @(negedge clk);
        imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h0010_0113;
        @(negedge clk);
        imem_rvalid = 0;
        cmp("consume pc_ir", pc_ir, 32'h30);
        fetch_start = 1; ir_consume = 1; pc_in = 32'h22;
        @(negedge clk);
        fetch_start = 0; ir_consume = 0;
        cmp("mis fault", 32'(fault), 1);
        cmp("mis cause", 32'(fault_cause), 1);
        cmp("mis imem_req", 32'(imem_req), 0);
        fetch_start = 1; pc_in = 32'h40;
        repeat (2) @(negedge clk);
        fetch_start = 0;
        cmp("mis pc_write", 32'(pc_write), 0);
        fault_clear = 1;
        @(negedge clk);
        fault_clear = 0;
        cmp("clear fault", 32'(fault), 0);
        cmp("clear busy", 32'(busy), 0);
        fetch_start = 1; pc_in = 32'h40;
        @(negedge clk);
        fetch_start = 0; imem_gnt = 1;
        @(negedge clk);
        imem_gnt = 0;
        repeat (3) @(negedge clk);
        cmp("tmo early fault", 32'(fault), 0);
        @(negedge clk);
        cmp("tmo cause", 32'(fault_cause), 2);
        fault_clear = 1;
        @(negedge clk);
        fault_clear = 0;
        do_fetch(32'h44, 0, T - 1, 32'hCAFE_0093, 0);
        cmp("tmo race ir_out", ir_out, 32'hCAFE_0093);
        cmp("tmo race fault", 32'(fault), 0);
        do_fetch(32'hFFFF_FFFC, 1, 0, 32'h0000_0073, 1);
        cmp("wrap pc_next", pc_next, 32'h0);
        cmp("wrap pc_ir", pc_ir, 32'hFFFF_FFFC);
        fetch_start = 1; ir_consume = 1; pc_in = 32'h100;
        @(negedge clk);
        fetch_start = 0; ir_consume = 0; imem_gnt = 1;
        @(negedge clk);
        imem_gnt = 0; rst = 1;
        @(negedge clk);
        rst = 0; imem_rvalid = 1; imem_rdata = 32'h1234_5678;
        @(negedge clk);
        imem_rvalid = 0;
        cmp("abort ir_valid", 32'(ir_valid), 0);
        cmp("abort pc_write", 32'(pc_write), 0);
        for (int i = 0; i < 2000; i++) begin
            d = $urandom;
            rst = ($urandom_range(99) == 0);
            fetch_start = ($urandom_range(9) < 3);
            ir_consume = ($urandom_range(9) < 3);
            fault_clear = ($urandom_range(9) < 2);
            imem_gnt = 1'($urandom);
            imem_rvalid = ($urandom_range(9) < 3);
            imem_rdata = $urandom;
            pc_in = ($urandom_range(9) == 0) ? d : ($urandom_range(19) == 0 ? 32'hFFFF_FFFC : {d[31:2], 2'b00});
            @(negedge clk);
        end
        rst = 0; fetch_start = 0; imem_gnt = 0; imem_rvalid = 0;
        @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Multicycle instruction fetch stage sitting directly downstream of the PC register in the RV32I multicycle core. On a fetch command from the control unit it reads the instruction at the current PC from instruction memory via a req/gnt/rvalid handshake. It then latches the instruction and its PC into the instruction register and drives PC+4 with a one-cycle write-enable back into the PC register. Misaligned PCs and memory timeouts are reported as sticky faults.

## Interface
- `TIMEOUT_CYCLES`, 255: maximum cycles spent in WAIT before a bus fault; range 1..255.
- `NOP_INSN`, 32'h0000_0013: instruction-register reset/flush value (`addi x0,x0,0`).

- `clk`  in  1  single clock; all state changes on posedge.
- `rst`  in  1  reset, synchronous and active-high.
- `pc_in`  in  32  current PC from the PC register.
- `fetch_start`  in  1  one-cycle fetch command from the control unit.
- `ir_consume`  in  1  decode has taken the held instruction.
- `fault_clear`  in  1  leaves FAULT and clears fault outputs.
- `imem_req`  out  1  memory read request.
- `imem_addr`  out  32  word-aligned read address.
- `imem_gnt`  in  1  memory accepted the request.
- `imem_rvalid`  in  1  read data valid.
- `imem_rdata`  in  32  read data.
- `ir_out`  out  32  instruction register.
- `pc_ir`  out  32  PC of the instruction in `ir_out`, for branch/JAL targets.
- `ir_valid`  out  1  `ir_out` holds an unconsumed instruction.
- `pc_next`  out  32  PC+4 of the fetched instruction.
- `pc_write`  out  1  one-cycle write-enable to the PC register.
- `busy`  out  1  FSM is not in IDLE.
- `fault`  out  1  sticky fault flag.
- `fault_cause`  out  2  0 none, 1 misaligned PC, 2 bus timeout.

## Operation
- **States:** IDLE, REQ, WAIT, FAULT. Reset goes to IDLE.
- **IDLE:**
  - `fetch_start` is accepted only if `ir_valid`=0 or `ir_consume`=1 in the same cycle. Otherwise it is ignored; the command is not queued.
  - On accept, latch `pc_in` as `fetch_pc`.
  - If `pc_in[1:0]`≠0, go to FAULT with cause 1. Otherwise go to REQ.
- **REQ:** `imem_req`=1 and `imem_addr`=`fetch_pc`, both held stable until `imem_gnt`. On `imem_gnt`, go to WAIT and clear the watchdog. `imem_rvalid` is ignored in REQ.
- **WAIT:** `imem_req`=0.
  - On `imem_rvalid`: `ir_out`←`imem_rdata`, `pc_ir`←`fetch_pc`, `pc_next`←`fetch_pc`+4 (modulo 2^32, so 0xFFFF_FFFC→0), `ir_valid`←1, `pc_write` pulses high for 1 cycle, then go to IDLE.
  - The watchdog counts WAIT cycles. On reaching `TIMEOUT_CYCLES` without `rvalid`, go to FAULT with cause 2. If `rvalid` and timeout coincide, `rvalid` wins.
- **FAULT:**
  - `fault`=1, `busy`=1, no memory request, `pc_write` never asserted.
  - `fault_clear` returns to IDLE with `fault`=0 and `fault_cause`=0.
  - `fetch_start` is ignored.
- **`ir_valid` clearing:** cleared by `ir_consume` when no new instruction is loaded in the same cycle. Load has priority over consume.
- **Flush:** `ir_out` is not cleared on consume. It holds its last value until the next load.
- **Reset values:**
  - state IDLE.
  - `imem_req` 0, `imem_addr` 0.
  - `ir_out` `NOP_INSN`.
  - `pc_ir` 0, `pc_next` 0.
  - `ir_valid` 0, `pc_write` 0.
  - `busy` 0, `fault` 0, `fault_cause` 0.
  - watchdog 0.
- **Reset mid-operation:** reset in any state aborts immediately. An outstanding `rvalid` arriving after reset is ignored, since the FSM is in IDLE.

## Timing
- All outputs are registered.
- **Best case:**
  - `fetch_start` in cycle 0.
  - `imem_req` in cycle 1.
  - `gnt` in cycle 1.
  - `rvalid` in cycle 2.
  - Cycle 3: `ir_out`/`ir_valid`/`pc_write`/`pc_next` valid.
  - The PC register updates on the edge ending cycle 3.
  - Latency from `fetch_start` to `ir_valid` is 3 cycles plus gnt wait plus rvalid wait.
- `pc_write` is exactly 1 cycle wide per successful fetch.
- Misaligned fault is visible in cycle 1.
- Timeout fault is visible `TIMEOUT_CYCLES`+1 cycles after the `gnt` cycle.

## Structure
- **Shared package `riscv_pkg`:**
  - `fetch_state_t` enum (IDLE, REQ, WAIT, FAULT).
  - `fetch_fault_t` enum (NONE, MISALIGNED, BUS_TIMEOUT).
  - `XLEN`=32.
  - `NOP_INSN` constant.
- **Sub-module `fetch_watchdog`:** 8-bit counter with `clear`/`enable` inputs and an `expired` output.
- The FSM and datapath registers stay in `instr_fetch_unit`.

## Test plan
- **Reset:** assert `rst` 2 cycles → `ir_out`=0x0000_0013, all other outputs 0, `busy`=0.
- **Best-case fetch:** `pc_in`=0x20, `fetch_start`, `gnt` immediately, `rvalid` next cycle with 0x00500093 → `ir_out`=0x00500093, `pc_ir`=0x20, `pc_next`=0x24, `pc_write` high exactly 1 cycle, `ir_valid`=1.
- **Stall:** `ir_valid`=1, `fetch_start` without `ir_consume` → no `imem_req`. Repeat with `ir_consume` in the same cycle → fetch proceeds.
- **Misaligned:** `pc_in`=0x22 → `fault`=1, `fault_cause`=1, no `imem_req`, no `pc_write`. `fault_clear` → back to IDLE.
- **Timeout:** `TIMEOUT_CYCLES`=4, `gnt` given, `rvalid` never arrives → `fault_cause`=2 on the 5th cycle after `gnt`. A second run with `rvalid` on the expiry cycle → successful load.
- **Wrap and abort:** `pc_in`=0xFFFF_FFFC fetch → `pc_next`=0. Then `rst` asserted while in WAIT, followed by a late `rvalid` → `ir_valid` stays 0.
